// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and FSM state types for the serial UART endpoint.
//   DATA_BITS  - payload bits per UART frame
//   tx_state_t - transmitter states (idle, start bit, data bits, stop bit)
//   rx_state_t - receiver states (idle, start bit, data bits, stop bit)
package serial_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clock, reset (async, active-low)
//   push, push_data : write request; ignored while full
//   pop             : read request; ignored while empty
//   head            : oldest entry, '0 while empty
//   empty, full     : status from registered pointers only
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/serial_uart_endpoint.sv
// serial_uart_endpoint: processor serial port <-> 8N1 UART bridge.
//   clock, reset (async, active-low)
//   serial_out/serial_wren_out : processor write into TX queue
//   serial_ready_in            : TX queue not full
//   serial_rden_out            : pop RX queue head
//   serial_in/serial_valid_in  : RX queue head (show-ahead) and not-empty
//   uart_rxd / uart_txd        : UART pins, idle high
//   tx_overflow, rx_overflow   : sticky drop flags
//   rx_frame_err               : one-cycle pulse on a zero stop bit
// Build option: define SERIAL_LOOPBACK_EN to feed the receiver from the
// internal transmit line; uart_txd then stays high and uart_rxd is ignored.
module serial_uart_endpoint
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] serial_out,
    input  logic                 serial_wren_out,
    input  logic                 serial_rden_out,
    output logic [DATA_BITS-1:0] serial_in,
    output logic                 serial_valid_in,
    output logic                 serial_ready_in,
    input  logic                 uart_rxd,
    output logic                 uart_txd,
    output logic                 tx_overflow,
    output logic                 rx_overflow,
    output logic                 rx_frame_err
);

    localparam int unsigned    CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- transmit ----------------
    logic                 tx_empty;
    logic                 tx_full;
    logic                 tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    tx_state_t            tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_line;
    logic                 tx_bit_end;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (serial_wren_out),
        .push_data (serial_out),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    assign serial_ready_in = !tx_full;
    assign tx_bit_end      = (tx_cnt == CNT_LAST);

    // Popping at the end of the stop bit chains frames with no idle gap.
    always_comb begin
        tx_pop = !tx_empty && ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_shift    <= '0;
            tx_line     <= 1'b1;
            tx_overflow <= 1'b0;
        end else begin
            if (serial_wren_out && tx_full) tx_overflow <= 1'b1;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_line  <= 1'b0;
                tx_cnt   <= '0;
                tx_state <= TX_START;
            end else begin
                case (tx_state)
                    TX_IDLE: tx_line <= 1'b1;
                    TX_START: begin
                        if (tx_bit_end) begin
                            tx_cnt   <= '0;
                            tx_idx   <= '0;
                            tx_line  <= tx_shift[0];
                            tx_state <= TX_DATA;
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (tx_bit_end) begin
                            tx_cnt <= '0;
                            if (tx_idx == 3'd7) begin
                                tx_line  <= 1'b1;
                                tx_state <= TX_STOP;
                            end else begin
                                tx_line  <= tx_shift[1];
                                tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                                tx_idx   <= tx_idx + 1'b1;
                            end
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                    TX_STOP: begin
                        if (tx_bit_end) begin
                            tx_cnt   <= '0;
                            tx_line  <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // ---------------- line selection ----------------
    logic rx_src;
`ifdef SERIAL_LOOPBACK_EN
    assign rx_src   = tx_line;
    assign uart_txd = 1'b1;
`else
    assign rx_src   = uart_rxd;
    assign uart_txd = tx_line;
`endif

    // ---------------- receive ----------------
    logic                 rx_s1;
    logic                 rx_s2;
    rx_state_t            rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_empty;
    logic                 rx_full;
    logic                 rx_push;
    logic                 rx_bit_end;

    assign rx_bit_end = (rx_cnt == CNT_LAST);

    always_comb begin
        rx_push = (rx_state == RX_STOP) && rx_bit_end && rx_s2;
    end

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (serial_rden_out),
        .head      (serial_in),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    assign serial_valid_in = !rx_empty;

    // After the half-bit wait in START every later sample lands mid-bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_overflow  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1        <= rx_src;
            rx_s2        <= rx_s1;
            rx_frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_s2) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == 3'd7) rx_state <= RX_STOP;
                        else                rx_idx   <= rx_idx + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2 && rx_full) rx_overflow  <= 1'b1;
                        if (!rx_s2)           rx_frame_err <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_uart_endpoint.sv
// Testbench for serial_uart_endpoint (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// A frame-level reference model (queues plus frame position arithmetic) is
// compared against the DUT pins on every falling edge; directed sections add
// literal expectations. Define SERIAL_LOOPBACK_EN to exercise the loopback build.
module tb_serial_uart_endpoint;

    localparam int CPB    = 4;
    localparam int DEPTH  = 8;
    localparam int FL     = 10 * CPB;
    // 2 synchronizer flops, one edge to leave idle, half a bit to mid-start,
    // then 9 whole bits to mid-stop where the byte is pushed.
    localparam int RX_LAT = 3 + CPB / 2 + 9 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] serial_out = '0;
    logic       serial_wren_out = 1'b0;
    logic       serial_rden_out = 1'b0;
    logic [7:0] serial_in;
    logic       serial_valid_in;
    logic       serial_ready_in;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;
    logic       tx_overflow;
    logic       rx_overflow;
    logic       rx_frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    serial_uart_endpoint #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .serial_out      (serial_out),
        .serial_wren_out (serial_wren_out),
        .serial_rden_out (serial_rden_out),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_ready_in (serial_ready_in),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd),
        .tx_overflow     (tx_overflow),
        .rx_overflow     (rx_overflow),
        .rx_frame_err    (rx_frame_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         at;
        logic [7:0] b;
        bit         ok;
    } rx_ev_t;

    logic [7:0] q_tx[$];
    logic [7:0] q_rx[$];
    rx_ev_t     rx_ev[$];
    rx_ev_t     ev;
    int         cyc     = 0;
    int         tx_pos  = -1;
    logic [7:0] tx_cur  = '0;
    bit         m_txovf = 1'b0;
    bit         m_rxovf = 1'b0;
    bit         m_ferr  = 1'b0;
    int         pre_tx;
    int         pre_rx;
    int         ferr_cnt = 0;

    always @(posedge clock) begin
        cyc++;
        if (!reset) begin
            q_tx.delete();
            q_rx.delete();
            rx_ev.delete();
            tx_pos  = -1;
            m_txovf = 1'b0;
            m_rxovf = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            pre_tx = q_tx.size();
            pre_rx = q_rx.size();
            if (tx_pos >= 0) tx_pos++;
            if (tx_pos < 0 || tx_pos == FL) begin
                if (pre_tx > 0) begin
                    tx_cur = q_tx.pop_front();
                    tx_pos = 0;
                end else begin
                    tx_pos = -1;
                end
            end
            if (serial_wren_out) begin
                if (pre_tx < DEPTH) q_tx.push_back(serial_out);
                else                m_txovf = 1'b1;
            end
            if (serial_rden_out && pre_rx > 0) void'(q_rx.pop_front());
            m_ferr = 1'b0;
            while (rx_ev.size() > 0 && rx_ev[0].at <= cyc) begin
                ev = rx_ev.pop_front();
                if (!ev.ok)             m_ferr = 1'b1;
                else if (pre_rx < DEPTH) q_rx.push_back(ev.b);
                else                     m_rxovf = 1'b1;
            end
        end
    end

    function automatic logic exp_txd();
        int k;
        if (tx_pos < 0) return 1'b1;
        k = tx_pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return tx_cur[k-1];
        return 1'b1;
    endfunction

    always @(negedge clock) begin
        if (rx_frame_err) ferr_cnt++;
        if (chk_en) begin
            if (!reset) begin
                check("rst_txd", uart_txd, 1);
                check("rst_ready", serial_ready_in, 1);
                check("rst_valid", serial_valid_in, 0);
                check("rst_serial_in", serial_in, 0);
                check("rst_flags", {tx_overflow, rx_overflow, rx_frame_err}, 0);
            end else begin
                check("txd", uart_txd, exp_txd());
                check("ready", serial_ready_in, q_tx.size() < DEPTH);
                check("valid", serial_valid_in, q_rx.size() > 0);
                if (q_rx.size() > 0) check("rx_head", serial_in, q_rx[0]);
                check("tx_overflow", tx_overflow, m_txovf);
                check("rx_overflow", rx_overflow, m_rxovf);
                check("rx_frame_err", rx_frame_err, m_ferr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_frame(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clock); #1;
        rx_ev.push_back('{at: cyc + RX_LAT, b: b, ok: stop});
        for (int k = 0; k < 10; k++) begin
            uart_rxd = f[k];
            repeat (CPB) @(posedge clock);
            #1;
        end
        uart_rxd = 1'b1;
        if (!stop) begin
            repeat (2 * CPB) @(posedge clock);
            #1;
        end
    endtask

    task automatic read_pulse();
        @(posedge clock); #1;
        serial_rden_out = 1'b1;
        @(posedge clock); #1;
        serial_rden_out = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic [9:0] a5_frame;
    logic [7:0] expb;
    int         acc;
    int         ferr0;
    bit         got;

    initial begin
`ifdef SERIAL_LOOPBACK_EN
        repeat (5) @(posedge clock);
        #1;
        check("lb_rst_txd", uart_txd, 1);
        check("lb_rst_valid", serial_valid_in, 0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        serial_out = 8'h5A;
        serial_wren_out = 1'b1;
        @(posedge clock); #1;
        serial_wren_out = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 45 && !got; i++) begin
            @(negedge clock);
            check("lb_txd_idle", uart_txd, 1);
            if (serial_valid_in) got = 1'b1;
        end
        check("lb_valid", serial_valid_in, 1);
        check("lb_data", serial_in, 8'h5A);
`else
        chk_en = 1'b1;
        // 1. reset values
        repeat (5) @(posedge clock);
        #1;
        check("t1_txd", uart_txd, 1);
        check("t1_valid", serial_valid_in, 0);
        check("t1_ready", serial_ready_in, 1);
        check("t1_flags", {tx_overflow, rx_overflow, rx_frame_err}, 0);
        reset = 1'b1;

        // 2. single byte frame, literal waveform
        repeat (3) @(posedge clock);
        #1;
        serial_out = 8'hA5;
        serial_wren_out = 1'b1;
        @(posedge clock); #1;
        serial_wren_out = 1'b0;
        @(posedge clock);
        a5_frame = 10'b1_1010_0101_0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CPB; j++) begin
                @(negedge clock);
                check("t2_a5_bit", uart_txd, a5_frame[k]);
            end
        end
        @(negedge clock);
        check("t2_idle_after", uart_txd, 1);

        // 3. receive 0x3C, read it, read while empty
        drive_frame(8'h3C, 1'b1);
        @(posedge clock);
        @(negedge clock);
        check("t3_valid", serial_valid_in, 1);
        check("t3_data", serial_in, 8'h3C);
        read_pulse();
        @(negedge clock);
        check("t3_valid_after_read", serial_valid_in, 0);
        read_pulse();
        @(negedge clock);
        check("t3_empty_read", serial_valid_in, 0);

        // 4. burst of 12 writes
        repeat (5) @(posedge clock);
        #1;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            serial_out = 8'(8'h10 + i);
            serial_wren_out = 1'b1;
            if (serial_ready_in) acc++;
            @(posedge clock); #1;
        end
        serial_wren_out = 1'b0;
        check("t4_accepted", acc, 9);
        check("t4_ready_low", serial_ready_in, 0);
        check("t4_tx_overflow", tx_overflow, 1);
        repeat (9 * FL + 20) @(posedge clock);
        #1;
        check("t4_drained_ready", serial_ready_in, 1);

        // 5. framing error, then RX overflow
        ferr0 = ferr_cnt;
        drive_frame(8'h77, 1'b0);
        check("t5_ferr_pulses", ferr_cnt - ferr0, 1);
        check("t5_valid_stays_0", serial_valid_in, 0);
        for (int i = 0; i < 9; i++) drive_frame(8'(8'h20 + i), 1'b1);
        repeat (3) @(posedge clock);
        #1;
        check("t5_rx_overflow", rx_overflow, 1);
        for (int i = 0; i < 8; i++) begin
            expb = 8'(8'h20 + i);
            @(negedge clock);
            check("t5_preserved", serial_in, expb);
            read_pulse();
        end
        @(negedge clock);
        check("t5_empty_after", serial_valid_in, 0);

        // randomized traffic after a fresh reset
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    serial_wren_out = ($urandom_range(0, 3) == 0);
                    serial_out = 8'($urandom);
                    @(posedge clock); #1;
                end
                serial_wren_out = 1'b0;
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    serial_rden_out = ($urandom_range(0, 2) == 0);
                    @(posedge clock); #1;
                end
                serial_rden_out = 1'b0;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(0, 5)) @(posedge clock);
                    drive_frame(8'($urandom), ($urandom_range(0, 7) != 0));
                end
            end
        join
        repeat ((DEPTH + 1) * FL + 100) @(posedge clock);
        #1;
        check("rand_tx_drained", serial_ready_in, 1);
        check("rand_txd_idle", uart_txd, 1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
